// File: rtl/up_counter_mod_if.sv
// Bus bundle for up_counter_mod: load/count controls in, count and status out.
// The master modport drives the controls; the slave modport is the counter side.
interface up_counter_mod_if #(
  parameter int WIDTH = 3
);
  logic             load_en;
  logic [WIDTH-1:0] data_in;
  logic             cnt_en;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q_out;
  logic             tc;
  logic             running;

  modport master (
    output load_en, data_in, cnt_en, limit,
    input  q_out, tc, running
  );

  modport slave (
    input  load_en, data_in, cnt_en, limit,
    output q_out, tc, running
  );
endinterface

// File: rtl/up_counter_mod.sv
// Loadable up counter with terminal-count pulse and IDLE/RUN control FSM.
// Define UP_COUNTER_ONESHOT_EN to stop in a DONE state at limit instead of wrapping.
module up_counter_mod #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  up_counter_mod_if.slave  bus
);

`ifdef UP_COUNTER_ONESHOT_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_p0, q_nxt;
  logic             tc_p0, tc_nxt;
  logic             running_p0;

  always_comb begin
    state_nxt = state;
    q_nxt     = q_p0;
    tc_nxt    = 1'b0;
    if (bus.load_en) begin
      q_nxt     = bus.data_in;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cnt_en) state_nxt = RUN;
        end
        RUN: begin
          if (!bus.cnt_en) begin
            state_nxt = IDLE;
          end else if (q_p0 == bus.limit) begin
`ifdef UP_COUNTER_ONESHOT_EN
            state_nxt = DONE;
`else
            q_nxt = '0;
`endif
          end else begin
            // tc marks only counts that arrive at limit by incrementing
            q_nxt  = q_p0 + 1'b1;
            tc_nxt = (q_nxt == bus.limit);
          end
        end
`ifdef UP_COUNTER_ONESHOT_EN
        DONE: begin
          state_nxt = DONE;
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register stage: state, count and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q_p0       <= '0;
      tc_p0      <= 1'b0;
      running_p0 <= 1'b0;
    end else begin
      state      <= state_nxt;
      q_p0       <= q_nxt;
      tc_p0      <= tc_nxt;
      running_p0 <= (state_nxt == RUN);
    end
  end

  assign bus.q_out   = q_p0;
  assign bus.tc      = tc_p0;
  assign bus.running = running_p0;

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed self-checking bench for up_counter_mod (WIDTH=3, limit=5 by default).
module tb_up_counter_mod;
  localparam int W = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  up_counter_mod_if #(.WIDTH(W)) bus ();

  up_counter_mod #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.load_en = 1'b0; bus.cnt_en = 1'b0;
    bus.data_in = '0; bus.limit = W'(5);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.load_en = 1'b1; bus.data_in = W'(7); bus.cnt_en = 1'b1; bus.limit = W'(5);
    tick();
    checks += 3;
    if (bus.q_out !== W'(0)) begin failures++; $display("FAIL reset_q got=%0d exp=0", bus.q_out); end
    if (bus.tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", bus.tc); end
    if (bus.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    reset = 1'b0; bus.load_en = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.q_out !== W'(2)) begin failures++; $display("FAIL reset_precount_q got=%0d exp=2", bus.q_out); end
    reset = 1'b1;
    tick();
    checks += 2;
    if (bus.q_out !== W'(0)) begin failures++; $display("FAIL reset_midcount_q got=%0d exp=0", bus.q_out); end
    if (bus.running !== 1'b0) begin failures++; $display("FAIL reset_midcount_running got=%b exp=0", bus.running); end
    reset = 1'b0; bus.cnt_en = 1'b0;
  endtask

`ifndef UP_COUNTER_ONESHOT_EN
  task automatic test_count_wrap();
    int eq[9] = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
    int et[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    do_reset();
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks += 3;
      if (bus.q_out !== W'(eq[i])) begin failures++; $display("FAIL count_q step%0d got=%0d exp=%0d", i, bus.q_out, eq[i]); end
      if (bus.tc !== et[i][0]) begin failures++; $display("FAIL count_tc step%0d got=%b exp=%0d", i, bus.tc, et[i]); end
      if (bus.running !== 1'b1) begin failures++; $display("FAIL count_running step%0d got=%b exp=1", i, bus.running); end
    end
    bus.cnt_en = 1'b0;
  endtask
`endif

  task automatic test_load();
    int eq[4] = '{2, 3, 4, 5};
    do_reset();
    bus.load_en = 1'b1; bus.data_in = W'(2);
    tick();
    checks += 2;
    if (bus.q_out !== W'(2)) begin failures++; $display("FAIL load_q got=%0d exp=2", bus.q_out); end
    if (bus.running !== 1'b0) begin failures++; $display("FAIL load_running got=%b exp=0", bus.running); end
    bus.load_en = 1'b0; bus.cnt_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 2;
      if (bus.q_out !== W'(eq[i])) begin failures++; $display("FAIL load_count_q step%0d got=%0d exp=%0d", i, bus.q_out, eq[i]); end
      if (bus.tc !== (i == 3)) begin failures++; $display("FAIL load_count_tc step%0d got=%b", i, bus.tc); end
    end
    // load and count together: load wins and FSM returns to IDLE
    bus.load_en = 1'b1; bus.data_in = W'(6);
    tick();
    checks += 3;
    if (bus.q_out !== W'(6)) begin failures++; $display("FAIL loadwin_q got=%0d exp=6", bus.q_out); end
    if (bus.running !== 1'b0) begin failures++; $display("FAIL loadwin_running got=%b exp=0", bus.running); end
    if (bus.tc !== 1'b0) begin failures++; $display("FAIL loadwin_tc got=%b exp=0", bus.tc); end
    bus.data_in = W'(5);
    tick();
    checks += 2;
    if (bus.q_out !== W'(5)) begin failures++; $display("FAIL loadlimit_q got=%0d exp=5", bus.q_out); end
    if (bus.tc !== 1'b0) begin failures++; $display("FAIL loadlimit_tc got=%b exp=0", bus.tc); end
    bus.load_en = 1'b0;
    tick();
    checks += 3;
    if (bus.q_out !== W'(5)) begin failures++; $display("FAIL loadlimit_run_q got=%0d exp=5", bus.q_out); end
    if (bus.tc !== 1'b0) begin failures++; $display("FAIL loadlimit_run_tc got=%b exp=0", bus.tc); end
    if (bus.running !== 1'b1) begin failures++; $display("FAIL loadlimit_running got=%b exp=1", bus.running); end
    bus.cnt_en = 1'b0;
  endtask

  task automatic test_pause();
    do_reset();
    bus.cnt_en = 1'b1;
    repeat (4) tick();
    checks++;
    if (bus.q_out !== W'(3)) begin failures++; $display("FAIL pause_pre_q got=%0d exp=3", bus.q_out); end
    bus.cnt_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 2;
      if (bus.q_out !== W'(3)) begin failures++; $display("FAIL pause_q step%0d got=%0d exp=3", i, bus.q_out); end
      if (bus.running !== 1'b0) begin failures++; $display("FAIL pause_running step%0d got=%b exp=0", i, bus.running); end
    end
    bus.cnt_en = 1'b1;
    tick();
    checks += 2;
    if (bus.q_out !== W'(3)) begin failures++; $display("FAIL resume_q0 got=%0d exp=3", bus.q_out); end
    if (bus.running !== 1'b1) begin failures++; $display("FAIL resume_running got=%b exp=1", bus.running); end
    tick();
    checks++;
    if (bus.q_out !== W'(4)) begin failures++; $display("FAIL resume_q1 got=%0d exp=4", bus.q_out); end
    tick();
    checks += 2;
    if (bus.q_out !== W'(5)) begin failures++; $display("FAIL resume_q2 got=%0d exp=5", bus.q_out); end
    if (bus.tc !== 1'b1) begin failures++; $display("FAIL resume_tc got=%b exp=1", bus.tc); end
    bus.cnt_en = 1'b0;
  endtask

  task automatic test_load_above_limit();
    int eq[8] = '{6, 7, 0, 1, 2, 3, 4, 5};
    do_reset();
    bus.load_en = 1'b1; bus.data_in = W'(6);
    tick();
    bus.load_en = 1'b0; bus.cnt_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks += 2;
      if (bus.q_out !== W'(eq[i])) begin failures++; $display("FAIL above_q step%0d got=%0d exp=%0d", i, bus.q_out, eq[i]); end
      if (bus.tc !== (i == 7)) begin failures++; $display("FAIL above_tc step%0d got=%b", i, bus.tc); end
    end
    bus.cnt_en = 1'b0;
  endtask

  task automatic test_limit_zero();
    int eq[3] = '{6, 7, 0};
    do_reset();
    bus.limit = W'(0);
    bus.load_en = 1'b1; bus.data_in = W'(6);
    tick();
    bus.load_en = 1'b0; bus.cnt_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (bus.q_out !== W'(eq[i])) begin failures++; $display("FAIL lim0_q step%0d got=%0d exp=%0d", i, bus.q_out, eq[i]); end
      if (bus.tc !== (i == 2)) begin failures++; $display("FAIL lim0_tc step%0d got=%b", i, bus.tc); end
    end
    tick();
    checks += 3;
    if (bus.q_out !== W'(0)) begin failures++; $display("FAIL lim0_hold_q got=%0d exp=0", bus.q_out); end
    if (bus.tc !== 1'b0) begin failures++; $display("FAIL lim0_hold_tc got=%b exp=0", bus.tc); end
`ifdef UP_COUNTER_ONESHOT_EN
    if (bus.running !== 1'b0) begin failures++; $display("FAIL lim0_hold_running got=%b exp=0", bus.running); end
`else
    if (bus.running !== 1'b1) begin failures++; $display("FAIL lim0_hold_running got=%b exp=1", bus.running); end
`endif
    // a second wrap after reload pulses tc again
    bus.load_en = 1'b1; bus.data_in = W'(7);
    tick();
    bus.load_en = 1'b0;
    tick();
    tick();
    checks += 2;
    if (bus.q_out !== W'(0)) begin failures++; $display("FAIL lim0_rewrap_q got=%0d exp=0", bus.q_out); end
    if (bus.tc !== 1'b1) begin failures++; $display("FAIL lim0_rewrap_tc got=%b exp=1", bus.tc); end
    bus.cnt_en = 1'b0; bus.limit = W'(5);
  endtask

`ifdef UP_COUNTER_ONESHOT_EN
  task automatic test_oneshot();
    do_reset();
    bus.cnt_en = 1'b1;
    repeat (6) tick();
    checks += 2;
    if (bus.q_out !== W'(5)) begin failures++; $display("FAIL oneshot_q got=%0d exp=5", bus.q_out); end
    if (bus.tc !== 1'b1) begin failures++; $display("FAIL oneshot_tc got=%b exp=1", bus.tc); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 3;
      if (bus.q_out !== W'(5)) begin failures++; $display("FAIL done_q step%0d got=%0d exp=5", i, bus.q_out); end
      if (bus.tc !== 1'b0) begin failures++; $display("FAIL done_tc step%0d got=%b exp=0", i, bus.tc); end
      if (bus.running !== 1'b0) begin failures++; $display("FAIL done_running step%0d got=%b exp=0", i, bus.running); end
      bus.cnt_en = ~bus.cnt_en;
    end
    bus.load_en = 1'b1; bus.data_in = W'(1); bus.cnt_en = 1'b0;
    tick();
    checks += 2;
    if (bus.q_out !== W'(1)) begin failures++; $display("FAIL done_load_q got=%0d exp=1", bus.q_out); end
    if (bus.running !== 1'b0) begin failures++; $display("FAIL done_load_running got=%b exp=0", bus.running); end
    bus.load_en = 1'b0; bus.cnt_en = 1'b1;
    tick();
    checks++;
    if (bus.running !== 1'b1) begin failures++; $display("FAIL done_exit_running got=%b exp=1", bus.running); end
    repeat (3) tick();
    checks++;
    if (bus.q_out !== W'(4)) begin failures++; $display("FAIL oneshot_pre_reset_q got=%0d exp=4", bus.q_out); end
    reset = 1'b1;
    tick();
    checks += 2;
    if (bus.q_out !== W'(0)) begin failures++; $display("FAIL oneshot_reset_q got=%0d exp=0", bus.q_out); end
    if (bus.running !== 1'b0) begin failures++; $display("FAIL oneshot_reset_running got=%b exp=0", bus.running); end
    reset = 1'b0; bus.cnt_en = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0; bus.load_en = 1'b0; bus.cnt_en = 1'b0;
    bus.data_in = '0; bus.limit = W'(5);
    test_reset();
`ifndef UP_COUNTER_ONESHOT_EN
    test_count_wrap();
`endif
    test_load();
    test_pause();
    test_load_above_limit();
    test_limit_zero();
`ifdef UP_COUNTER_ONESHOT_EN
    test_oneshot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
